axi_config_rd_pipe: RTL

Pipelined AXI4 read slave that turns AXI read bursts into single-beat `rd`/`raddr` strobes toward a register or config space, and returns in-order `rdata`/`rvalid` responses through a parameterised response FIFO. It is the next generation of the config-space read bridge. It adds:
- data-width-derived address increment;
- FIXED, INCR and WRAP bursts;
- credit-based flow control that tolerates any backend latency and arbitrary `s_axi_rready` backpressure;
- SLVERR reporting.

It sits between an AXI interconnect master port and the config register file.

---
 rtl/axi_config_rd_pipe.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_config_rd_pipe.sv
// axi_config_rd_pipe: AXI4 read slave that converts FIXED/INCR/WRAP read bursts
// into single-beat rd/raddr strobes toward a config register space. In-order
// responses are returned through a credit-managed response FIFO.
// Optional backend watchdog and post-timeout quarantine: define
// AXI_CONFIG_RD_PIPE_TIMEOUT_EN.
module axi_config_rd_pipe #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic [3:0]            s_axi_arregion,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  rd,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid
);

  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ERR, S_QUAR} state_t;

  state_t                state_q;
  logic                  arready_q;
  logic                  rd_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [ADDR_WIDTH-1:0] wmask_q;
  logic [8:0]            iss_q;   // beats issued to the backend
  logic [8:0]            ret_q;   // beats popped on the R channel (head index)
  logic [8:0]            enq_q;   // beats written into the FIFO
  logic [CW-1:0]         out_q;   // rd strobes still awaiting backend rvalid
  logic [CW-1:0]         cnt_q;   // FIFO occupancy
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_err_q;

  logic                  ar_hs;
  logic                  active;
  logic [8:0]            last_idx;
  logic                  fifo_vld;
  logic                  pop;
  logic                  pop_last;
  logic                  bk_push;
  logic                  fill_push;
  logic                  push;
  logic                  credit;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] raddr_d;
  logic                  wd_fire;
  logic                  timed_out;
  logic                  quar_done;
  logic                  unused_ok;

  // WRAP window mask; non-WRAP and illegal WRAP lengths use a full mask (INCR)
  function automatic logic [ADDR_WIDTH-1:0] wrap_mask(input logic [1:0] burst,
                                                      input logic [7:0] len);
    logic [ADDR_WIDTH-1:0] m;
    m = '1;
    if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      m = (ADDR_WIDTH'(len) << LSB) | LOW_MASK;
    return m;
  endfunction

  assign ar_hs     = s_axi_arvalid && arready_q;
  assign active    = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_ERR);
  assign last_idx  = {1'b0, len_q} + 9'd1;
  assign fifo_vld  = (cnt_q != '0);
  assign pop       = fifo_vld && s_axi_rready;
  assign pop_last  = pop && (ret_q == {1'b0, len_q});
  assign bk_push   = rvalid && (out_q != '0);
  assign fill_push = ((state_q == S_ERR) || (timed_out && active)) && !bk_push &&
                     (enq_q < last_idx) && (cnt_q < CW'(FIFO_DEPTH));
  assign push      = bk_push || fill_push;
  // Credits count outstanding reads plus stored beats; a same-cycle pop is not credited.
  assign credit    = ({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(FIFO_DEPTH);
  assign issue     = (state_q == S_ISSUE) && (iss_q != last_idx) && credit &&
                     !timed_out && !wd_fire;
  assign step      = (burst_q == 2'b00) ? '0 : STEP;
  assign raddr_d   = (raddr_q & ~wmask_q) | ((raddr_q + step) & wmask_q);

  assign s_axi_arready = arready_q;
  assign rd            = rd_q;
  assign raddr         = raddr_q;
  assign s_axi_rid     = id_q;
  assign s_axi_rvalid  = fifo_vld;
  assign s_axi_rdata   = fifo_vld ? fifo_data_q[rptr_q] : '0;
  assign s_axi_rresp   = (fifo_vld && fifo_err_q[rptr_q]) ? 2'b10 : 2'b00;
  assign s_axi_rlast   = fifo_vld && (ret_q == {1'b0, len_q});

  assign unused_ok = ^{s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                       s_axi_arqos, s_axi_arregion, 32'(TIMEOUT_CYCLES)};

`ifdef AXI_CONFIG_RD_PIPE_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic           to_q;
  logic [WDW-1:0] wd_q;
  logic [WDW-1:0] qcnt_q;

  assign wd_fire   = !to_q && (out_q != '0) && !rvalid && (wd_q == WDW'(TIMEOUT_CYCLES - 1));
  assign timed_out = to_q;
  assign quar_done = (qcnt_q == WDW'(TIMEOUT_CYCLES - 1));

  // Backend watchdog and quarantine counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q   <= 1'b0;
      wd_q   <= '0;
      qcnt_q <= '0;
    end else begin
      if (ar_hs)        to_q <= 1'b0;
      else if (wd_fire) to_q <= 1'b1;
      if (rvalid || (out_q == '0) || wd_fire) wd_q <= '0;
      else                                    wd_q <= wd_q + WDW'(1);
      if (state_q == S_QUAR) qcnt_q <= qcnt_q + WDW'(1);
      else                   qcnt_q <= '0;
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign timed_out = 1'b0;
  assign quar_done = 1'b1;
`endif

  // Burst FSM, issue/return counters, FIFO pointers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rd_q      <= 1'b0;
      raddr_q   <= '0;
      id_q      <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      wmask_q   <= '0;
      iss_q     <= '0;
      ret_q     <= '0;
      enq_q     <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      arready_q <= 1'b0;
      rd_q      <= 1'b0;
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
        enq_q  <= enq_q + 9'd1;
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
        ret_q  <= ret_q + 9'd1;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (wd_fire) out_q <= '0;
      else         out_q <= out_q + CW'(issue) - CW'(bk_push);
      if (issue) begin
        rd_q    <= 1'b1;
        raddr_q <= raddr_d;
        iss_q   <= iss_q + 9'd1;
      end
      case (state_q)
        S_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            id_q      <= s_axi_arid;
            len_q     <= s_axi_arlen;
            burst_q   <= s_axi_arburst;
            wmask_q   <= wrap_mask(s_axi_arburst, s_axi_arlen);
            raddr_q   <= s_axi_araddr & ~LOW_MASK;
            ret_q     <= '0;
            enq_q     <= '0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            if (s_axi_arburst == 2'b11) begin
              state_q <= S_ERR;
              iss_q   <= '0;
              out_q   <= '0;
            end else begin
              // First beat issues in the cycle right after the handshake.
              state_q <= S_ISSUE;
              rd_q    <= 1'b1;
              iss_q   <= 9'd1;
              out_q   <= CW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (iss_q == last_idx || timed_out) state_q <= S_DRAIN;
        end
        S_QUAR: begin
          if (quar_done) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (pop_last) begin
        state_q   <= timed_out ? S_QUAR : S_IDLE;
        arready_q <= !timed_out;
      end
    end
  end

  // Response FIFO storage; payload only, occupancy lives in the FSM block
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wptr_q] <= bk_push ? rdata : '0;
      fifo_err_q[wptr_q]  <= fill_push;
    end
  end

endmodule
